// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter: whole-cycle grants, fair alternation under
// contention, and a stall timeout that answers the owner with a one-cycle err.
`timescale 1ns/1ps

module wb_arbiter2 #(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,

   input  logic          m0_cyc,
   input  logic          m0_stb,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_adr,
   input  logic [DW-1:0] m0_dat_i,
   output logic [DW-1:0] m0_dat_o,
   output logic          m0_ack,
   output logic          m0_err,

   input  logic          m1_cyc,
   input  logic          m1_stb,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_adr,
   input  logic [DW-1:0] m1_dat_i,
   output logic [DW-1:0] m1_dat_o,
   output logic          m1_ack,
   output logic          m1_err,

   output logic          s_cyc,
   output logic          s_stb,
   output logic          s_we,
   output logic [AW-1:0] s_adr,
   output logic [DW-1:0] s_dat_o,
   input  logic [DW-1:0] s_dat_i,
   input  logic          s_ack,

   output logic [1:0]    grant
);

   // A zero TIMEOUT would give a zero-width counter; keep one bit that stays cleared.
   localparam int            CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
   localparam bit            TO_EN  = (TIMEOUT > 0);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      G0   = 2'b01,
      G1   = 2'b10
   } state_t;

   state_t        state, state_next;
   logic          last, last_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          expired;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values; blocking here would create order-dependent simulation races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_next;
         last  <= last_next;
         cnt   <= cnt_next;
      end
   end

   // NOTE: every output of a combinational block gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_next = state;
      last_next  = last;
      unique case (state)
         IDLE: begin
            if (m0_cyc && m1_cyc) state_next = last ? G0 : G1;
            else if (m0_cyc)      state_next = G0;
            else if (m1_cyc)      state_next = G1;
         end
         G0: begin
            if (!m0_cyc) begin
               last_next  = 1'b0;
               state_next = m1_cyc ? G1 : IDLE;
            end
         end
         G1: begin
            if (!m1_cyc) begin
               last_next  = 1'b1;
               state_next = m0_cyc ? G0 : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // An owner that lets go of cyc in the expiry cycle never sees err.
   always_comb begin
      expired = 1'b0;
      if (TO_EN && cnt == TO_VAL) begin
         unique case (state)
            G0:      expired = m0_cyc;
            G1:      expired = m1_cyc;
            default: expired = 1'b0;
         endcase
      end
   end

   always_comb begin
      s_cyc   = 1'b0;
      s_stb   = 1'b0;
      s_we    = 1'b0;
      s_adr   = '0;
      s_dat_o = '0;
      m0_ack  = 1'b0;
      m0_err  = 1'b0;
      m1_ack  = 1'b0;
      m1_err  = 1'b0;
      grant   = 2'b00;
      unique case (state)
         G0: begin
            s_cyc   = m0_cyc;
            s_stb   = m0_stb & ~expired;
            s_we    = m0_we;
            s_adr   = m0_adr;
            s_dat_o = m0_dat_i;
            m0_ack  = s_ack;
            m0_err  = expired;
            grant   = 2'b01;
         end
         G1: begin
            s_cyc   = m1_cyc;
            s_stb   = m1_stb & ~expired;
            s_we    = m1_we;
            s_adr   = m1_adr;
            s_dat_o = m1_dat_i;
            m1_ack  = s_ack;
            m1_err  = expired;
            grant   = 2'b10;
         end
         default: ;
      endcase
   end

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

   // s_stb is forced low in the err cycle, so the same clear term restarts the count.
   always_comb begin
      cnt_next = cnt;
      if (!TO_EN || state_next != state || s_ack || !s_stb) begin
         cnt_next = '0;
      end else if (cnt != TO_VAL) begin
         cnt_next = cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Scoreboarded bench for wb_arbiter2: one instance with TIMEOUT=4 and one with the
// timeout disabled share the master stimulus; each has its own stub slave.
`timescale 1ns/1ps

module tb_wb_arbiter2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [15:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
   logic        slave_en;

   logic [15:0] m0_rdat, m1_rdat, s_adr, s_wdat, s_rdat;
   logic        m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we, s_ack;
   logic [1:0]  grant;

   logic [15:0] n_m0_rdat, n_m1_rdat, n_s_adr, n_s_wdat, n_s_rdat;
   logic        n_m0_ack, n_m0_err, n_m1_ack, n_m1_err, n_s_cyc, n_s_stb, n_s_we, n_s_ack;
   logic [1:0]  n_grant;

   function automatic logic [15:0] slave_rd(input logic [15:0] a);
      return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
   endfunction

   assign s_rdat   = slave_rd(s_adr);
   assign s_ack    = slave_en & s_cyc & s_stb;
   assign n_s_rdat = slave_rd(n_s_adr);
   assign n_s_ack  = slave_en & n_s_cyc & n_s_stb;

   wb_arbiter2 #(.AW(16), .DW(16), .TIMEOUT(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
      .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat), .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
      .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat), .m1_ack(m1_ack), .m1_err(m1_err),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
      .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack(s_ack), .grant(grant)
   );

   wb_arbiter2 #(.AW(16), .DW(16), .TIMEOUT(0)) u_dut_nt (
      .clk(clk), .rst_n(rst_n),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
      .m0_dat_i(m0_wdat), .m0_dat_o(n_m0_rdat), .m0_ack(n_m0_ack), .m0_err(n_m0_err),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
      .m1_dat_i(m1_wdat), .m1_dat_o(n_m1_rdat), .m1_ack(n_m1_ack), .m1_err(n_m1_err),
      .s_cyc(n_s_cyc), .s_stb(n_s_stb), .s_we(n_s_we), .s_adr(n_s_adr),
      .s_dat_o(n_s_wdat), .s_dat_i(n_s_rdat), .s_ack(n_s_ack), .grant(n_grant)
   );

   typedef struct packed {
      logic [1:0]  grant;
      logic        we;
      logic [15:0] adr;
      logic [15:0] dat;
   } txn_t;

   txn_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   err_to4, err_nt;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                        input logic [15:0] adr, input logic [15:0] dat);
      if (m == 0) begin
         m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_wdat = dat;
      end else begin
         m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_wdat = dat;
      end
   endtask

   task automatic expect_txn(input logic [1:0] g, input logic we, input logic [15:0] adr,
                             input logic [15:0] wdat);
      txn_t t;
      t.grant = g;
      t.we    = we;
      t.adr   = adr;
      t.dat   = we ? wdat : slave_rd(adr);
      sb.push_back(t);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   // Every slave-side handshake retires the oldest expected transfer.
   always @(negedge clk) begin
      txn_t        e;
      logic [15:0] d;
      logic        a;
      if (rst_n && s_cyc && s_stb && s_ack) begin
         if (sb.size() == 0) begin
            check("sb_unexpected", 64'(sb.size()), 64'd1);
         end else begin
            e = sb.pop_front();
            if (grant == 2'b01) begin
               d = s_we ? s_wdat : m0_rdat;
               a = m0_ack;
            end else begin
               d = s_we ? s_wdat : m1_rdat;
               a = m1_ack;
            end
            check("sb_txn", {a, grant, s_we, s_adr, d}, {1'b1, e.grant, e.we, e.adr, e.dat});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      drive(0, 0, 0, 0, 16'h0, 16'h0);
      drive(1, 0, 0, 0, 16'h0, 16'h0);
      slave_en = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_grant", grant, 2'b00);
      check("rst_s_bus", {s_cyc, s_stb, s_we, s_adr, s_wdat}, 0);
      check("rst_ack_err", {m0_ack, m0_err, m1_ack, m1_err}, 0);
      rst_n = 1'b1;

      // Single m0 read, zero-wait slave
      tick; drive(0, 1, 1, 0, 16'h0010, 16'h0);
      expect_txn(2'b01, 1'b0, 16'h0010, 16'h0);
      smp;  check("t1_idle_grant", grant, 2'b00);
            check("t1_idle_stb", s_stb, 1'b0);
      tick; smp;
      check("t1_grant", grant, 2'b01);
      check("t1_ack", m0_ack, 1'b1);
      check("t1_rdat", m0_rdat, 16'hBEEF);
      tick; drive(0, 0, 0, 0, 16'h0, 16'h0); smp;
      tick; smp; check("t1_release", grant, 2'b00);

      // Contention: m0 owned last, so m1 wins; handover with no idle cycle
      tick; drive(0, 1, 1, 1, 16'h0020, 16'h1111); drive(1, 1, 1, 1, 16'h0030, 16'h2222);
      expect_txn(2'b10, 1'b1, 16'h0030, 16'h2222);
      expect_txn(2'b01, 1'b1, 16'h0020, 16'h1111);
      smp;  check("t2_idle", grant, 2'b00);
      tick; smp;
      check("t2_first", grant, 2'b10);
      check("t2_m0_blocked", m0_ack, 1'b0);
      tick; drive(1, 0, 0, 0, 16'h0, 16'h0); smp;
      check("t2_m1_drop", grant, 2'b10);
      check("t2_m0_wait", m0_ack, 1'b0);
      tick; smp;
      check("t2_handover", grant, 2'b01);
      check("t2_m0_ack", m0_ack, 1'b1);
      tick; drive(0, 0, 0, 0, 16'h0, 16'h0); smp;
      tick; smp; check("t2_idle_after", grant, 2'b00);

      tick; drive(0, 1, 1, 0, 16'h0021, 16'h0); drive(1, 1, 1, 0, 16'h0031, 16'h0);
      expect_txn(2'b10, 1'b0, 16'h0031, 16'h0);
      expect_txn(2'b01, 1'b0, 16'h0021, 16'h0);
      smp;
      tick; smp; check("t2_second_winner", grant, 2'b10);
      tick; drive(1, 0, 0, 0, 16'h0, 16'h0); smp;
      tick; smp; check("t2_second_handover", grant, 2'b01);
      tick; drive(0, 0, 0, 0, 16'h0, 16'h0); smp;
      tick; smp; check("t2_second_idle", grant, 2'b00);

      // m1 burst of three writes while m0 waits
      tick; drive(1, 1, 1, 1, 16'h0100, 16'h0001);
      for (int i = 0; i < 3; i++) expect_txn(2'b10, 1'b1, 16'(16'h0100 + i), 16'(i + 1));
      expect_txn(2'b01, 1'b0, 16'h0040, 16'h0);
      smp;
      for (int i = 0; i < 4; i++) begin
         tick;
         if (i == 0) drive(0, 1, 1, 0, 16'h0040, 16'h0);
         if (i == 1) drive(1, 1, 1, 1, 16'h0101, 16'h0002);
         if (i == 2) drive(1, 1, 1, 1, 16'h0102, 16'h0003);
         if (i == 3) drive(1, 0, 0, 0, 16'h0, 16'h0);
         smp;
         check($sformatf("t3_grant_%0d", i), grant, 2'b10);
         check($sformatf("t3_m0_ack_%0d", i), m0_ack, 1'b0);
      end
      tick; smp;
      check("t3_m0_grant", grant, 2'b01);
      check("t3_m0_ack", m0_ack, 1'b1);
      tick; drive(0, 0, 0, 0, 16'h0, 16'h0); smp;
      tick; smp; check("t3_idle", grant, 2'b00);

      // Timeout = 4 with a silent slave: err every fifth granted cycle, stb low then
      slave_en = 1'b0;
      tick; drive(0, 1, 1, 0, 16'h0050, 16'h0); smp;
      for (int k = 1; k <= 10; k++) begin
         tick; smp;
         check($sformatf("t4_err_%0d", k), m0_err, (k == 5 || k == 10));
         check($sformatf("t4_stb_%0d", k), s_stb, !(k == 5 || k == 10));
         check($sformatf("t4_grant_%0d", k), grant, 2'b01);
         check($sformatf("t4_nt_err_%0d", k), n_m0_err, 1'b0);
      end
      tick; drive(0, 0, 0, 0, 16'h0, 16'h0); smp;
      tick; smp; check("t4_idle", grant, 2'b00);

      // Owner drops cyc in the expiry cycle: err suppressed
      tick; drive(0, 1, 1, 0, 16'h0050, 16'h0); smp;
      for (int k = 1; k <= 4; k++) begin
         tick; smp;
      end
      tick; drive(0, 0, 1, 0, 16'h0050, 16'h0); smp;
      check("t4b_err_suppressed", m0_err, 1'b0);
      tick; drive(0, 0, 0, 0, 16'h0, 16'h0); smp;
      check("t4b_idle", grant, 2'b00);
      check("t4b_err_after", m0_err, 1'b0);

      // 300-cycle stall: disabled timeout never errs, TIMEOUT=4 errs every 5 cycles
      err_to4 = 0;
      err_nt  = 0;
      tick; drive(0, 1, 1, 0, 16'h0060, 16'h0); smp;
      for (int k = 1; k <= 300; k++) begin
         tick; smp;
         err_nt  += int'(n_m0_err | n_m1_err);
         err_to4 += int'(m0_err);
      end
      check("t5_nt_err_count", err_nt, 0);
      check("t5_to4_err_count", err_to4, 60);
      check("t5_nt_stb", {n_grant, n_s_stb}, {2'b01, 1'b1});
      tick; drive(0, 0, 0, 0, 16'h0, 16'h0); smp;
      tick; smp;

      // Asynchronous reset while m1 is mid-access
      tick; drive(1, 1, 1, 0, 16'h0070, 16'h0); smp;
      tick; smp;
      check("t6_pre_grant", grant, 2'b10);
      check("t6_pre_cyc", s_cyc, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_s_cyc", s_cyc, 1'b0);
      check("t6_grant", grant, 2'b00);
      check("t6_bus", {s_stb, s_we, s_adr, m1_ack, m1_err}, 0);
      drive(1, 0, 0, 0, 16'h0, 16'h0);
      slave_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      tick; drive(0, 1, 1, 1, 16'h0080, 16'hAAAA); drive(1, 1, 1, 1, 16'h0090, 16'hBBBB);
      expect_txn(2'b01, 1'b1, 16'h0080, 16'hAAAA);
      expect_txn(2'b10, 1'b1, 16'h0090, 16'hBBBB);
      smp;
      tick; smp; check("t6_m0_wins", grant, 2'b01);
      tick; drive(0, 0, 0, 0, 16'h0, 16'h0); smp;
      tick; smp; check("t6_m1_next", grant, 2'b10);
      tick; drive(1, 0, 0, 0, 16'h0, 16'h0); smp;
      tick; smp; check("t6_idle", grant, 2'b00);

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
